// File: rtl/otter_pl_csr_intr.sv
// rtl/otter_pl_csr_intr.sv - Machine-mode CSR file and external interrupt controller for the pipelined OTTER core
//
// Purpose:
//   Holds mstatus (MIE/MPIE), mie (MEIE), mtvec, mepc and mcause, reports
//   mip (MEIP), executes CSR instructions and MRET committed in writeback, and
//   raises the one-cycle INT_TAKEN strobe that steers the decoder to mtvec.
//
// Configuration:
//   OTTER_INTR_SYNC_EN - when defined, INTR passes through a two-flop
//   synchronizer before edge detection (+2 cycles of latency). When undefined,
//   INTR must be synchronous to CLK.
//
// Ports:
//   CLK, RST          pipeline clock, synchronous active-high reset
//   INTR              external interrupt request (level)
//   ID_VALID, ID_PC   decode-stage instruction valid and its PC
//   STALL, FLUSH      decode-stage stall / flush for this cycle
//   CSR_WE, CSR_FUNC3, CSR_ADDR, CSR_WDATA, CSR_SRC_ZERO
//                     committing CSR instruction from writeback
//   MRET_COMMIT       MRET commits in writeback
//   CSR_RD            pre-write value of CSR_ADDR (combinational)
//   INT_TAKEN         interrupt taken this cycle (combinational)
//   MTVEC, MEPC       redirect targets
//   INT_PENDING       latched pending interrupt

module otter_pl_csr_intr #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] MCAUSE_EXT = 'h8000_000B
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INTR,
  input  logic            ID_VALID,
  input  logic [XLEN-1:0] ID_PC,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            CSR_WE,
  input  logic [2:0]      CSR_FUNC3,
  input  logic [11:0]     CSR_ADDR,
  input  logic [XLEN-1:0] CSR_WDATA,
  input  logic            CSR_SRC_ZERO,
  input  logic            MRET_COMMIT,
  output logic [XLEN-1:0] CSR_RD,
  output logic            INT_TAKEN,
  output logic [XLEN-1:0] MTVEC,
  output logic [XLEN-1:0] MEPC,
  output logic            INT_PENDING
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            meie_q, meie_d;
  logic            pending_q, pending_d;
  logic            intr_prev_q;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic            intr_s;
  logic            intr_rise;
  logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
  logic [XLEN-1:0] csr_old, csr_new;
  logic            csr_wr;
  logic            take;

  // The *I forms arrive with zimm already zero-extended, so funct3[2] carries
  // no information here; PC bits [1:0] are dropped because mepc is aligned.
  logic            unused_bits;
  assign unused_bits = CSR_FUNC3[2] ^ ID_PC[1] ^ ID_PC[0];

`ifdef OTTER_INTR_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= INTR;
      sync2_q <= sync1_q;
    end
  end

  assign intr_s = sync2_q;
`else
  assign intr_s = INTR;
`endif

  assign intr_rise = intr_s & ~intr_prev_q;

  // Never take during reset: the state update is discarded that cycle, so a
  // redirect to mtvec would have no matching mepc/mcause.
  assign take = pending_q & mie_q & meie_q & ID_VALID & ~STALL & ~FLUSH
              & ~MRET_COMMIT & ~RST;

  always_comb begin
    mstatus_val     = '0;
    mstatus_val[3]  = mie_q;
    mstatus_val[7]  = mpie_q;
    mie_val         = '0;
    mie_val[11]     = meie_q;
    mip_val         = '0;
    mip_val[11]     = pending_q;
  end

  always_comb begin
    csr_old = '0;
    case (CSR_ADDR)
      ADDR_MSTATUS: csr_old = mstatus_val;
      ADDR_MIE:     csr_old = mie_val;
      ADDR_MTVEC:   csr_old = mtvec_q;
      ADDR_MEPC:    csr_old = mepc_q;
      ADDR_MCAUSE:  csr_old = mcause_q;
      ADDR_MIP:     csr_old = mip_val;
      default:      csr_old = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_old;
    case (CSR_FUNC3[1:0])
      2'b01:   csr_new = CSR_WDATA;
      2'b10:   csr_new = csr_old | CSR_WDATA;
      2'b11:   csr_new = csr_old & ~CSR_WDATA;
      default: csr_new = csr_old;
    endcase
  end

  // Set/clear with a zero source is a pure read and must not write.
  assign csr_wr = CSR_WE & (CSR_FUNC3[1:0] != 2'b00) & ~(CSR_FUNC3[1] & CSR_SRC_ZERO);

  // Order encodes priority: CSR write, then MRET, then take.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;

    if (csr_wr) begin
      case (CSR_ADDR)
        ADDR_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        ADDR_MIE:    meie_d   = csr_new[11];
        ADDR_MTVEC:  mtvec_d  = {csr_new[XLEN-1:2], 2'b00};
        ADDR_MEPC:   mepc_d   = {csr_new[XLEN-1:2], 2'b00};
        ADDR_MCAUSE: mcause_d = csr_new;
        default: ;
      endcase
    end

    if (MRET_COMMIT) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (take) begin
      mepc_d   = {ID_PC[XLEN-1:2], 2'b00};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = MCAUSE_EXT;
    end
  end

  // Edges arriving while already pending are absorbed by the OR.
  assign pending_d = take ? 1'b0 : (pending_q | intr_rise);

  always_ff @(posedge CLK) begin
    if (RST) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      meie_q      <= 1'b0;
      pending_q   <= 1'b0;
      intr_prev_q <= 1'b0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
    end else begin
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      meie_q      <= meie_d;
      pending_q   <= pending_d;
      intr_prev_q <= intr_s;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
    end
  end

  assign CSR_RD      = csr_old;
  assign INT_TAKEN   = take;
  assign MTVEC       = mtvec_q;
  assign MEPC        = mepc_q;
  assign INT_PENDING = pending_q;

endmodule

// File: tb/tb_otter_pl_csr_intr.sv
// tb/tb_otter_pl_csr_intr.sv - Self-checking bench for otter_pl_csr_intr

module tb_otter_pl_csr_intr;

`ifdef OTTER_INTR_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        intr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        stall;
  logic        flush;
  logic        csr_we;
  logic [2:0]  csr_func3;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic        mret;
  logic [31:0] csr_rd;
  logic        int_taken;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        int_pending;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  otter_pl_csr_intr dut (
    .CLK          (clk),
    .RST          (rst),
    .INTR         (intr),
    .ID_VALID     (id_valid),
    .ID_PC        (id_pc),
    .STALL        (stall),
    .FLUSH        (flush),
    .CSR_WE       (csr_we),
    .CSR_FUNC3    (csr_func3),
    .CSR_ADDR     (csr_addr),
    .CSR_WDATA    (csr_wdata),
    .CSR_SRC_ZERO (csr_src_zero),
    .MRET_COMMIT  (mret),
    .CSR_RD       (csr_rd),
    .INT_TAKEN    (int_taken),
    .MTVEC        (mtvec),
    .MEPC         (mepc),
    .INT_PENDING  (int_pending)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        sz;
    logic [31:0] exp_rd;
    logic [31:0] exp_mtvec;
    logic [31:0] exp_mepc;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [11:0] a,
                     input logic [31:0] wd, input logic sz, input logic [31:0] rd,
                     input logic [31:0] tv, input logic [31:0] ep);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.sz = sz;
    v.exp_rd = rd; v.exp_mtvec = tv; v.exp_mepc = ep;
    vt.push_back(v);
  endtask

  task automatic do_mret(input string nm);
    @(negedge clk);
    mret = 1'b1; csr_addr = 12'h300;
    #1 chk({nm, "_mret_taken"}, 32'(int_taken), 32'd0);
    @(negedge clk);
    mret = 1'b0;
    #1 chk({nm, "_mret_mstatus"}, csr_rd, 32'h88);
  endtask

  task automatic held_take(input logic use_flush, input string nm);
    @(negedge clk);
    intr = 1'b1; stall = ~use_flush; flush = use_flush;
    for (int j = 1; j <= L + 2; j++) begin
      @(negedge clk);
      intr = 1'b0;
      #1 chk({nm, "_held_taken"}, 32'(int_taken), 32'd0);
      chk({nm, "_held_pend"}, 32'(int_pending), (j >= L) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    #1 chk({nm, "_release_taken"}, 32'(int_taken), 32'd1);
    @(negedge clk);
    #1 chk({nm, "_after_taken"}, 32'(int_taken), 32'd0);
    chk({nm, "_after_pend"}, 32'(int_pending), 32'd0);
    do_mret(nm);
  endtask

  initial begin
    rst = 1'b1; intr = 1'b0; id_valid = 1'b0; id_pc = '0; stall = 1'b0; flush = 1'b0;
    csr_we = 1'b0; csr_func3 = '0; csr_addr = '0; csr_wdata = '0; csr_src_zero = 1'b0;
    mret = 1'b0;

    //   we  f3    addr    wdata         sz  rd            mtvec     mepc
    add(0, 3'b000, 12'h300, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h304, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h305, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h341, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h342, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h7C0, 32'h0,        0, 32'h0,        32'h0,    32'h0);
    add(1, 3'b001, 12'h305, 32'h103,      0, 32'h0,        32'h0,    32'h0);
    add(0, 3'b000, 12'h305, 32'h0,        0, 32'h100,      32'h100,  32'h0);
    add(1, 3'b010, 12'h300, 32'h8,        0, 32'h0,        32'h100,  32'h0);
    add(0, 3'b000, 12'h300, 32'h0,        0, 32'h8,        32'h100,  32'h0);
    add(1, 3'b011, 12'h300, 32'h8,        1, 32'h8,        32'h100,  32'h0);
    add(0, 3'b000, 12'h300, 32'h0,        0, 32'h8,        32'h100,  32'h0);
    add(1, 3'b001, 12'h300, 32'hFFFFFFFF, 0, 32'h8,        32'h100,  32'h0);
    add(0, 3'b000, 12'h300, 32'h0,        0, 32'h88,       32'h100,  32'h0);
    add(1, 3'b011, 12'h300, 32'h80,       0, 32'h88,       32'h100,  32'h0);
    add(0, 3'b000, 12'h300, 32'h0,        0, 32'h8,        32'h100,  32'h0);
    add(1, 3'b010, 12'h304, 32'hFFFFFFFF, 0, 32'h0,        32'h100,  32'h0);
    add(0, 3'b000, 12'h304, 32'h0,        0, 32'h800,      32'h100,  32'h0);
    add(1, 3'b001, 12'h341, 32'h1237,     0, 32'h0,        32'h100,  32'h0);
    add(0, 3'b000, 12'h341, 32'h0,        0, 32'h1234,     32'h100,  32'h1234);
    add(1, 3'b001, 12'h342, 32'hDEADBEEF, 0, 32'h0,        32'h100,  32'h1234);
    add(0, 3'b000, 12'h342, 32'h0,        0, 32'hDEADBEEF, 32'h100,  32'h1234);
    add(1, 3'b000, 12'h342, 32'h0,        0, 32'hDEADBEEF, 32'h100,  32'h1234);
    add(0, 3'b000, 12'h342, 32'h0,        0, 32'hDEADBEEF, 32'h100,  32'h1234);
    add(1, 3'b001, 12'h7C0, 32'h55,       0, 32'h0,        32'h100,  32'h1234);
    add(0, 3'b000, 12'h7C0, 32'h0,        0, 32'h0,        32'h100,  32'h1234);
    add(1, 3'b101, 12'h305, 32'h1F,       0, 32'h100,      32'h100,  32'h1234);
    add(0, 3'b000, 12'h305, 32'h0,        0, 32'h1C,       32'h1C,   32'h1234);
    add(0, 3'b000, 12'h344, 32'h0,        0, 32'h0,        32'h1C,   32'h1234);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      csr_we = vt[i].we; csr_func3 = vt[i].f3; csr_addr = vt[i].addr;
      csr_wdata = vt[i].wdata; csr_src_zero = vt[i].sz;
      #1;
      chk($sformatf("v%0d_rd", i), csr_rd, vt[i].exp_rd);
      chk($sformatf("v%0d_mtvec", i), mtvec, vt[i].exp_mtvec);
      chk($sformatf("v%0d_mepc", i), mepc, vt[i].exp_mepc);
      chk($sformatf("v%0d_taken", i), 32'(int_taken), 32'd0);
      chk($sformatf("v%0d_pend", i), 32'(int_pending), 32'd0);
    end
    @(negedge clk);
    csr_we = 1'b0; csr_func3 = '0; csr_wdata = '0; csr_src_zero = 1'b0;

    // Basic take: MIE=1, MEIE=1, one-cycle INTR pulse.
    intr = 1'b1; id_valid = 1'b1; id_pc = 32'h40; csr_addr = 12'h344;
    #1 chk("a_pre_taken", 32'(int_taken), 32'd0);
    for (int j = 1; j <= L + 2; j++) begin
      @(negedge clk);
      intr = 1'b0;
      #1 chk($sformatf("a_taken_c%0d", j), 32'(int_taken), (j == L) ? 32'd1 : 32'd0);
      chk($sformatf("a_pend_c%0d", j), 32'(int_pending), (j == L) ? 32'd1 : 32'd0);
      chk($sformatf("a_mip_c%0d", j), csr_rd, (j == L) ? 32'h800 : 32'h0);
    end
    @(negedge clk);
    csr_addr = 12'h342;
    #1 chk("a_mcause", csr_rd, 32'h8000000B);
    chk("a_mepc", mepc, 32'h40);
    @(negedge clk);
    csr_addr = 12'h300;
    #1 chk("a_mstatus", csr_rd, 32'h80);
    do_mret("a");

    held_take(1'b0, "stall");
    held_take(1'b1, "flush");

    // MRET in the cycle a take would fire suppresses it; take follows.
    @(negedge clk);
    intr = 1'b1;
    for (int j = 1; j < L; j++) begin
      @(negedge clk);
      intr = 1'b0;
    end
    @(negedge clk);
    intr = 1'b0; mret = 1'b1;
    #1 chk("e_pend", 32'(int_pending), 32'd1);
    chk("e_mret_taken", 32'(int_taken), 32'd0);
    @(negedge clk);
    mret = 1'b0;
    #1 chk("e_next_taken", 32'(int_taken), 32'd1);
    @(negedge clk);
    #1 chk("e_after_taken", 32'(int_taken), 32'd0);
    do_mret("e");

    // Second edge while pending is absorbed; CSR write to mepc in the take
    // cycle is overridden by the take.
    @(negedge clk);
    intr = 1'b1; stall = 1'b1;
    @(negedge clk); intr = 1'b0;
    @(negedge clk); intr = 1'b1;
    @(negedge clk); intr = 1'b0;
    for (int j = 1; j <= L + 2; j++) begin
      @(negedge clk);
      #1 chk("f_pend", 32'(int_pending), 32'd1);
    end
    @(negedge clk);
    stall = 1'b0; csr_we = 1'b1; csr_func3 = 3'b001; csr_addr = 12'h341;
    csr_wdata = 32'h999; id_pc = 32'h80;
    #1 chk("f_taken", 32'(int_taken), 32'd1);
    @(negedge clk);
    csr_we = 1'b0; csr_wdata = '0;
    #1 chk("f_after_taken", 32'(int_taken), 32'd0);
    chk("f_mepc", mepc, 32'h80);
    chk("f_pend_clr", 32'(int_pending), 32'd0);
    do_mret("f");
    for (int j = 1; j <= L + 3; j++) begin
      @(negedge clk);
      #1 chk("f_no2_taken", 32'(int_taken), 32'd0);
      chk("f_no2_pend", 32'(int_pending), 32'd0);
    end

    // Reset while pending: no take in the reset cycle, state cleared.
    @(negedge clk);
    intr = 1'b1; stall = 1'b1;
    for (int j = 1; j <= L + 1; j++) begin
      @(negedge clk);
      intr = 1'b0;
    end
    #1 chk("h_pend", 32'(int_pending), 32'd1);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0;
    #1 chk("h_rst_taken", 32'(int_taken), 32'd0);
    @(negedge clk);
    rst = 1'b0; csr_addr = 12'h300;
    #1 chk("h_pend_clr", 32'(int_pending), 32'd0);
    chk("h_mstatus", csr_rd, 32'h0);
    chk("h_mtvec", mtvec, 32'h0);
    chk("h_taken", 32'(int_taken), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_pl_csr_intr.md
# otter_pl_csr_intr

Machine-mode CSR file and interrupt controller for the pipelined OTTER core. It is the upstream end of the decoder's trap interface. It:
- raises the one-cycle interrupt-take strobe the decoder uses to select the mtvec PC source;
- supplies the mtvec and mepc redirect targets;
- executes committed CSR instructions and MRET state restores from writeback.

It sits beside the register file and is clocked with the pipeline.

## Interface
Parameters:
- XLEN, 32, data width of all CSRs.
- MCAUSE_EXT, 32'h8000_000B, value loaded into mcause on interrupt take (machine external interrupt).

Ports:
- CLK  in  1  pipeline clock.
- RST  in  1  reset, synchronous, active-high.
- INTR  in  1  external interrupt request, level, may be asynchronous.
- ID_VALID  in  1  decode stage holds a valid instruction.
- ID_PC  in  32  PC of the decode-stage instruction.
- STALL  in  1  decode stage stalled this cycle.
- FLUSH  in  1  decode stage being flushed by a redirect this cycle.
- CSR_WE  in  1  CSR instruction commits in writeback this cycle.
- CSR_FUNC3  in  3  funct3 of the committing CSR instruction.
- CSR_ADDR  in  12  CSR address.
- CSR_WDATA  in  32  rs1 value, or zero-extended zimm for the *I forms.
- CSR_SRC_ZERO  in  1  rs1/zimm field is zero.
- MRET_COMMIT  in  1  MRET commits in writeback this cycle.
- CSR_RD  out  32  current value of CSR_ADDR (combinational), to RF write mux.
- INT_TAKEN  out  1  interrupt taken this cycle (to decoder intTaken).
- MTVEC  out  32  trap vector.
- MEPC  out  32  return address.
- INT_PENDING  out  1  latched pending interrupt.

## Operation
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - mie 0x304: only MEIE[11] is writable.
  - mtvec 0x305: bits [1:0] forced to 0 (direct mode).
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342: fully writable.
  - mip 0x344: read-only; bit 11 = pending.
- Any other address reads 0; writes to it are ignored.
- CSR write when CSR_WE=1, by CSR_FUNC3[1:0]:
  - 01 (RW): new = WDATA.
  - 10 (RS): new = old | WDATA.
  - 11 (RC): new = old & ~WDATA.
  - 00: no write.
  - RS/RC with CSR_SRC_ZERO=1 perform no write.
  - CSR_RD always returns the pre-write value.
- Pending latch:
  - Set on a rising edge of the (optionally synchronized) INTR.
  - Cleared on take.
  - Held otherwise; further edges while pending are absorbed.
- INT_TAKEN = pending & MIE & MEIE & ID_VALID & ~STALL & ~FLUSH & ~MRET_COMMIT. It is combinational.
- On a take edge:
  - mepc <= ID_PC.
  - MPIE <= MIE; MIE <= 0.
  - mcause <= MCAUSE_EXT.
  - pending <= 0.
- On MRET_COMMIT: MIE <= MPIE; MPIE <= 1.
- Same-cycle priorities:
  - A CSR write and a take in the same cycle: the write commits first, then the take overrides mepc, mcause and the MIE/MPIE fields.
  - A CSR write to mstatus and an MRET in the same cycle: the MRET wins on MIE/MPIE.
  - MRET_COMMIT and a take are mutually exclusive by the INT_TAKEN gating.
- MTVEC and MEPC are driven directly from the registers.

## Timing
- Reset (RST high at an edge): all CSRs = 0, pending = 0, edge-detect and synchronizer flops = 0. INT_TAKEN = 0 and CSR_RD = 0 (for an implemented address) the cycle after.
- RST asserted mid-trap clears pending and MIE. No take occurs in the reset cycle.
- CSR writes are visible on CSR_RD, MTVEC and MEPC the cycle after the commit edge.
- INTR-to-INT_TAKEN latency, from INTR high before edge k, with gating true:
  - without sync: pending high after edge k; INT_TAKEN in cycle k+1.
  - with sync: pending high after edge k+2; INT_TAKEN in cycle k+3.
- INT_TAKEN is high for exactly one cycle per take. MIE is cleared on that edge, so back-to-back takes are impossible.
- A take held off by STALL or FLUSH remains pending and fires in the first cycle the gating clears.

## Configuration
- OTTER_INTR_SYNC_EN defined: INTR passes through a two-flop synchronizer before edge detection. This adds 2 cycles of latency.
- OTTER_INTR_SYNC_EN undefined: INTR feeds edge detection directly. INTR must then be synchronous to CLK.

## Test plan
- Reset then read 0x300/0x304/0x305/0x341/0x342 → all 0. Read 0x7C0 → 0.
- CSRRW mtvec 0x0000_0103 → MTVEC = 0x0000_0100 next cycle. CSRRS mstatus 0x8 → MIE = 1. CSRRC with CSR_SRC_ZERO=1 → no change.
- MIE=1, MEIE=1, INTR pulse, ID_PC = 0x0000_0040, no stall (macro undefined):
  - INT_TAKEN one cycle after the INTR edge.
  - mepc = 0x40, mcause = 0x8000_000B, MIE = 0, MPIE = 1.
- Pending with STALL=1 for 3 cycles → INT_TAKEN held off, then asserted in the first unstalled cycle. FLUSH behaves the same.
- MRET_COMMIT with MPIE=1 → MIE = 1, MPIE = 1. MRET in the same cycle as a would-be take → INT_TAKEN = 0, take occurs the next cycle.
- Macro defined: INTR high before edge k → INT_TAKEN in cycle k+3. A second INTR edge while pending → only one take.
